// File: rtl/lms_fir_seq.sv
// Sequencer and LMS coefficient engine for a 9-tap pipelined FIR: replays sample history into the
// filter, captures y(n), forms the error against d(n) and adapts the taps one per cycle.
module lms_fir_seq #(
    parameter int          MU_SHIFT    = 16,
    parameter logic [15:0] CENTER_INIT = 16'h0000
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          sample_valid_i,
    input  logic [15:0]   sample_i,
    input  logic [15:0]   desired_i,
    input  logic          adapt_en_i,
    input  logic          coef_load_i,
    input  logic [3:0]    coef_load_idx_i,
    input  logic [15:0]   coef_load_data_i,
    input  logic          ovr_clr_i,
    output logic [15:0]   fir_din_o,
    input  logic [15:0]   fir_dout_i,
    output logic [143:0]  coef_o,
    output logic [15:0]   y_o,
    output logic [15:0]   err_o,
    output logic          out_valid_o,
    output logic          busy_o,
    output logic          overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PUSH = 3'd1,
        S_WAIT = 3'd2,
        S_CAPT = 3'd3,
        S_UPD  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_nxt_s;

    logic signed [15:0] hist_r [0:8];
    logic signed [15:0] coef_r [0:8];
    logic signed [15:0] desired_r;
    logic [15:0]        fir_din_r;
    logic signed [15:0] y_r;
    logic signed [15:0] err_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               overrun_r;

    logic               accept_s;
    logic               load_s;
    logic [15:0]        fir_din_nxt_s;
    logic               out_valid_nxt_s;
    logic               busy_nxt_s;
    logic               overrun_nxt_s;
    logic signed [31:0] prod_s;
    logic signed [31:0] delta_s;
    logic signed [32:0] coef_sum_s;
    logic signed [32:0] diff_s;
    logic signed [15:0] coef_upd_s;
    logic signed [15:0] err_nxt_s;

    // Clamp a wide signed value into the 16-bit signed range.
    function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
        logic signed [15:0] r;
        if (v > 33'sd32767) begin
            r = 16'sh7FFF;
        end else if (v < -33'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    // State and phase counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= S_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: PUSH 9, WAIT 5, CAPT 1, optional UPD 9 cycles.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (sample_valid_i) begin
                    state_nxt_s = S_PUSH;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s = 4'd0;
                end
            end
            S_PUSH: begin
                if (cnt_r == 4'd8) begin
                    state_nxt_s = S_WAIT;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end
            end
            S_WAIT: begin
                if (cnt_r == 4'd4) begin
                    state_nxt_s = S_CAPT;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end
            end
            S_CAPT: begin
                cnt_nxt_s = 4'd0;
                if (adapt_en_i) begin
                    state_nxt_s = S_UPD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_UPD: begin
                if (cnt_r == 4'd8) begin
                    state_nxt_s = S_IDLE;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Output/next-value logic; fir_din looks one slot ahead because it is registered.
    always_comb begin
        accept_s        = 1'b0;
        load_s          = 1'b0;
        fir_din_nxt_s   = 16'h0000;
        out_valid_nxt_s = 1'b0;
        busy_nxt_s      = (state_nxt_s != S_IDLE);
        case (state_r)
            S_IDLE: begin
                accept_s = sample_valid_i;
                load_s   = coef_load_i && (coef_load_idx_i >= 4'd1) && (coef_load_idx_i <= 4'd9);
                if (sample_valid_i) begin
                    fir_din_nxt_s = hist_r[7];
                end else begin
                    fir_din_nxt_s = 16'h0000;
                end
            end
            S_PUSH: begin
                if (cnt_r < 4'd8) begin
                    fir_din_nxt_s = hist_r[4'd7 - cnt_r];
                end else begin
                    fir_din_nxt_s = 16'h0000;
                end
            end
            S_CAPT: begin
                out_valid_nxt_s = 1'b1;
            end
            default: begin
                fir_din_nxt_s = 16'h0000;
            end
        endcase
        if (sample_valid_i && (state_r != S_IDLE)) begin
            overrun_nxt_s = 1'b1;
        end else if (ovr_clr_i) begin
            overrun_nxt_s = 1'b0;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    // Shared multiplier for the coefficient update and saturated error subtract.
    always_comb begin
        prod_s     = err_r * hist_r[cnt_r];
        delta_s    = prod_s >>> MU_SHIFT;
        coef_sum_s = 33'(coef_r[cnt_r]) + 33'(delta_s);
        coef_upd_s = sat16(coef_sum_s);
        diff_s     = 33'(desired_r) - 33'($signed(fir_dout_i));
        err_nxt_s  = sat16(diff_s);
    end

    // Datapath registers: history, coefficients, captured results and status outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < 9; k++) begin
                hist_r[k] <= 16'sh0000;
                coef_r[k] <= 16'sh0000;
            end
            coef_r[4]   <= CENTER_INIT;
            desired_r   <= 16'sh0000;
            fir_din_r   <= 16'h0000;
            y_r         <= 16'sh0000;
            err_r       <= 16'sh0000;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                for (int k = 8; k > 0; k--) begin
                    hist_r[k] <= hist_r[k-1];
                end
                hist_r[0] <= sample_i;
                desired_r <= desired_i;
            end
            if (load_s) begin
                coef_r[coef_load_idx_i - 4'd1] <= coef_load_data_i;
            end
            if (state_r == S_UPD) begin
                coef_r[cnt_r] <= coef_upd_s;
            end
            if (state_r == S_CAPT) begin
                y_r   <= fir_dout_i;
                err_r <= err_nxt_s;
            end
            fir_din_r   <= fir_din_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= busy_nxt_s;
            overrun_r   <= overrun_nxt_s;
        end
    end

    for (genvar g = 0; g < 9; g++) begin : g_coef_out
        assign coef_o[16*g +: 16] = coef_r[g];
    end

    assign fir_din_o   = fir_din_r;
    assign y_o         = y_r;
    assign err_o       = err_r;
    assign out_valid_o = out_valid_r;
    assign busy_o      = busy_r;
    assign overrun_o   = overrun_r;

endmodule
